// File: rtl/ibex_trace_packetizer.sv
// ibex_trace_packetizer
// Captures RVFI retirements into a small record FIFO. Each record is
// serialized as four 32-bit words (header, PC, instruction, data) on a
// valid/ready stream. Records arriving while the FIFO is full are dropped.
// Drops are counted, and the next record that is captured carries a drop flag
// in its header.
//
// Stream handshake: a word transfers on a clock edge where trace_valid_o and
// trace_ready_i are both high. While trace_valid_o is high and trace_ready_i
// is low, trace_data_o and trace_last_o hold. trace_valid_o only falls after a
// handshake or on reset.
module ibex_trace_packetizer #(
    parameter int unsigned Depth        = 4,
    parameter int unsigned DropCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    trace_en_i,
    input  logic                    drop_clr_i,
    input  logic                    rvfi_valid,
    input  logic [63:0]             rvfi_order,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_intr,
    input  logic [31:0]             rvfi_insn,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [31:0]             rvfi_mem_addr,
    input  logic [3:0]              rvfi_mem_rmask,
    input  logic [3:0]              rvfi_mem_wmask,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [31:0]             trace_data_o,
    output logic                    trace_last_o,
    output logic [DropCntWidth-1:0] drop_cnt_o,
    output logic                    overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    // Word index of the record being presented; the encoding doubles as the
    // word select into the head record.
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PC   = 2'd1,
        ST_INSN = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [3:0][31:0]        rec_q [Depth];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic                    drop_pending_q, drop_pending_d;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                    overflow_q, overflow_d;

    logic        capture;
    logic        full;
    logic        push;
    logic        drop;
    logic        handshake;
    logic        pop;
    logic [31:0] hdr_word;
    logic [31:0] data_word;
    logic [1:0]  word_sel;

    // Only the low 12 bits of the retirement index are carried in the header.
    logic unused_order;
    assign unused_order = ^rvfi_order[63:12];

    // Fullness uses the count before this cycle's pop, so a full FIFO drops
    // even when a record completes in the same cycle.
    assign capture   = rvfi_valid & trace_en_i;
    assign full      = (count_q == DepthC);
    assign push      = capture & ~full;
    assign drop      = capture & full;
    assign handshake = trace_valid_o & trace_ready_i;
    assign pop       = handshake & (state_q == ST_DATA);

    // Build the header and data words of the incoming record.
    always_comb begin
        hdr_word = {4'hA, rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_mem_wmask,
                    rvfi_mem_rmask, drop_pending_q, rvfi_order[11:0]};
        if (rvfi_rd_addr != 5'd0) begin
            data_word = rvfi_rd_wdata;
        end else if ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0) begin
            data_word = rvfi_mem_addr;
        end else begin
            data_word = 32'h0;
        end
    end

    // FIFO pointer/count, drop bookkeeping next-state.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        drop_pending_d = drop_pending_q;
        drop_cnt_d     = drop_cnt_q;
        overflow_d     = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A drop and a push are mutually exclusive, so the flag is either
        // raised by a drop or consumed by the record that carries it.
        if (drop) begin
            drop_pending_d = 1'b1;
        end else if (push) begin
            drop_pending_d = 1'b0;
        end

        // A clear coinciding with a drop leaves exactly that one drop counted.
        if (drop_clr_i) begin
            drop_cnt_d = drop ? DropCntWidth'(1) : '0;
            overflow_d = drop;
        end else if (drop) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
            end
            overflow_d = 1'b1;
        end
    end

    // FIFO storage, pointers and drop bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                rec_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            drop_pending_q <= 1'b0;
            drop_cnt_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            if (push) begin
                rec_q[wr_ptr_q] <= {data_word, rvfi_insn, rvfi_pc_rdata, hdr_word};
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            drop_pending_q <= drop_pending_d;
            drop_cnt_q     <= drop_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer next state: step one word per handshake, wrap after DATA.
    always_comb begin
        state_d = state_q;
        if (handshake) begin
            case (state_q)
                ST_HDR:  state_d = ST_PC;
                ST_PC:   state_d = ST_INSN;
                ST_INSN: state_d = ST_DATA;
                ST_DATA: state_d = ST_HDR;
                default: state_d = ST_HDR;
            endcase
        end
    end

    // Serializer outputs: present the head record word selected by the state.
    always_comb begin
        word_sel      = state_q;
        trace_valid_o = (count_q != '0);
        trace_last_o  = (state_q == ST_DATA) & trace_valid_o;
        trace_data_o  = rec_q[rd_ptr_q][word_sel];
    end

    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ibex_trace_packetizer.sv
// Directed bench for ibex_trace_packetizer: single records, backpressure,
// overflow/drop flag, counter saturation and clear, reset mid-record.
module tb_ibex_trace_packetizer;

  logic        clk;
  logic        rst_i;
  logic        trace_en_i;
  logic        drop_clr_i;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [31:0] rvfi_insn;
  logic [31:0] rvfi_pc_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_data_o;
  logic        trace_last_o;
  logic [15:0] drop_cnt_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  ibex_trace_packetizer #(
    .Depth        (4),
    .DropCntWidth (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .trace_en_i     (trace_en_i),
    .drop_clr_i     (drop_clr_i),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_trap      (rvfi_trap),
    .rvfi_intr      (rvfi_intr),
    .rvfi_insn      (rvfi_insn),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_data_o   (trace_data_o),
    .trace_last_o   (trace_last_o),
    .drop_cnt_o     (drop_cnt_o),
    .overflow_o     (overflow_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle past it before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] order, input logic trap, input logic intr,
                       input logic [31:0] pc, input logic [31:0] insn,
                       input logic [4:0] rd, input logic [31:0] wdata,
                       input logic [31:0] maddr, input logic [3:0] rmask,
                       input logic [3:0] wmask);
    rvfi_valid     = 1'b1;
    rvfi_order     = {52'h0, order};
    rvfi_trap      = trap;
    rvfi_intr      = intr;
    rvfi_pc_rdata  = pc;
    rvfi_insn      = insn;
    rvfi_rd_addr   = rd;
    rvfi_rd_wdata  = wdata;
    rvfi_mem_addr  = maddr;
    rvfi_mem_rmask = rmask;
    rvfi_mem_wmask = wmask;
  endtask

  task automatic idle();
    rvfi_valid = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    trace_en_i     = 1'b1;
    drop_clr_i     = 1'b0;
    trace_ready_i  = 1'b1;
    rvfi_valid     = 1'b0;
    rvfi_order     = 64'h0;
    rvfi_trap      = 1'b0;
    rvfi_intr      = 1'b0;
    rvfi_insn      = 32'h0;
    rvfi_pc_rdata  = 32'h0;
    rvfi_rd_addr   = 5'd0;
    rvfi_rd_wdata  = 32'h0;
    rvfi_mem_addr  = 32'h0;
    rvfi_mem_rmask = 4'h0;
    rvfi_mem_wmask = 4'h0;

    // reset state
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_valid", 32'(trace_valid_o), 32'd0);
    check("rst_last", 32'(trace_last_o), 32'd0);
    check("rst_data", trace_data_o, 32'h0);
    check("rst_dropcnt", 32'(drop_cnt_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);

    // single ALU retirement, ready high
    drive(12'd7, 1'b0, 1'b0, 32'h100, 32'h00500093, 5'd1, 32'd5, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    check("alu_w0_valid", 32'(trace_valid_o), 32'd1);
    check("alu_w0", trace_data_o, 32'hA0200007);
    check("alu_w0_last", 32'(trace_last_o), 32'd0);
    tick();
    check("alu_w1", trace_data_o, 32'h00000100);
    tick();
    check("alu_w2", trace_data_o, 32'h00500093);
    tick();
    check("alu_w3", trace_data_o, 32'h00000005);
    check("alu_w3_last", 32'(trace_last_o), 32'd1);
    tick();
    check("alu_done_valid", 32'(trace_valid_o), 32'd0);

    // store with rd=0: data word is the memory address
    drive(12'd8, 1'b0, 1'b0, 32'h104, 32'h00112023, 5'd0, 32'h0, 32'h2000, 4'h0, 4'hF);
    tick();
    idle();
    check("st_w0", trace_data_o, 32'hA01E0008);
    tick();
    tick();
    tick();
    check("st_w3", trace_data_o, 32'h00002000);
    check("st_w3_last", 32'(trace_last_o), 32'd1);
    tick();
    check("st_done_valid", 32'(trace_valid_o), 32'd0);

    // trapping load in a handler entry, read mask only
    drive(12'h0AB, 1'b1, 1'b1, 32'h500, 32'h0000A083, 5'd0, 32'h0, 32'h3004, 4'h3, 4'h0);
    tick();
    idle();
    check("ld_w0", trace_data_o, 32'hAC0060AB);
    tick();
    tick();
    tick();
    check("ld_w3", trace_data_o, 32'h00003004);
    tick();
    check("ld_done_valid", 32'(trace_valid_o), 32'd0);

    // capture disabled: nothing queued
    trace_en_i = 1'b0;
    drive(12'd9, 1'b0, 1'b0, 32'h108, 32'h13, 5'd1, 32'd1, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    trace_en_i = 1'b1;
    check("en_off_valid", 32'(trace_valid_o), 32'd0);
    check("en_off_dropcnt", 32'(drop_cnt_o), 32'd0);

    // backpressure while presenting the instruction word
    drive(12'd9, 1'b0, 1'b0, 32'h108, 32'h13, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    check("bp_w0", trace_data_o, 32'hA0000009);
    tick();
    check("bp_w1", trace_data_o, 32'h00000108);
    tick();
    check("bp_w2", trace_data_o, 32'h00000013);
    trace_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", trace_data_o, 32'h00000013);
      check("bp_hold_valid", 32'(trace_valid_o), 32'd1);
    end
    trace_ready_i = 1'b1;
    tick();
    check("bp_w3", trace_data_o, 32'h00000000);
    check("bp_w3_last", 32'(trace_last_o), 32'd1);
    tick();
    check("bp_done_valid", 32'(trace_valid_o), 32'd0);

    // overflow: six retirements into a stalled FIFO of depth 4
    trace_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(12'(16 + i), 1'b0, 1'b0, 32'(32'h200 + 4 * i), 32'h13, 5'd2, 32'(i),
            32'h0, 4'h0, 4'h0);
      tick();
    end
    idle();
    check("ovf_dropcnt", 32'(drop_cnt_o), 32'd2);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_head_w0", trace_data_o, 32'hA0400010);
    trace_ready_i = 1'b1;
    tick();
    tick();
    tick();
    check("ovf_r0_w3", trace_data_o, 32'h00000000);
    tick();
    trace_ready_i = 1'b0;
    check("ovf_r1_w0", trace_data_o, 32'hA0400011);
    drive(12'h016, 1'b0, 1'b0, 32'h300, 32'h13, 5'd2, 32'h66, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    check("ovf_r1_hold", trace_data_o, 32'hA0400011);
    trace_ready_i = 1'b1;
    repeat (12) tick();
    check("ovf_flagged_w0", trace_data_o, 32'hA0401016);
    tick();
    tick();
    tick();
    check("ovf_flagged_w3", trace_data_o, 32'h00000066);
    tick();
    check("ovf_drain_valid", 32'(trace_valid_o), 32'd0);
    check("ovf_dropcnt_kept", 32'(drop_cnt_o), 32'd2);
    drive(12'h017, 1'b0, 1'b0, 32'h304, 32'h13, 5'd2, 32'h77, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    check("ovf_clean_w0", trace_data_o, 32'hA0400017);
    repeat (4) tick();
    check("ovf_clean_done", 32'(trace_valid_o), 32'd0);

    // clear, then saturate the drop counter
    drop_clr_i = 1'b1;
    tick();
    drop_clr_i = 1'b0;
    check("clr_dropcnt", 32'(drop_cnt_o), 32'd0);
    check("clr_ovf", 32'(overflow_o), 32'd0);
    trace_ready_i = 1'b0;
    drive(12'h040, 1'b0, 1'b0, 32'h300, 32'h13, 5'd3, 32'h55, 32'h0, 4'h0, 4'h0);
    repeat (4 + 65534) tick();
    check("sat_dropcnt_fffe", 32'(drop_cnt_o), 32'h0000FFFE);
    check("sat_head_w0", trace_data_o, 32'hA0600040);
    repeat (5) tick();
    check("sat_dropcnt_ffff", 32'(drop_cnt_o), 32'h0000FFFF);
    check("sat_ovf", 32'(overflow_o), 32'd1);
    drop_clr_i = 1'b1;
    tick();
    drop_clr_i = 1'b0;
    idle();
    check("clr_drop_dropcnt", 32'(drop_cnt_o), 32'd1);
    check("clr_drop_ovf", 32'(overflow_o), 32'd1);

    // reset mid-record with three records queued
    trace_ready_i = 1'b1;
    repeat (4) tick();
    tick();
    check("mid_w1", trace_data_o, 32'h00000300);
    tick();
    check("mid_w2", trace_data_o, 32'h00000013);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_valid", 32'(trace_valid_o), 32'd0);
    check("mid_rst_last", 32'(trace_last_o), 32'd0);
    check("mid_rst_dropcnt", 32'(drop_cnt_o), 32'd0);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    tick();
    check("mid_rst_idle", 32'(trace_valid_o), 32'd0);
    drive(12'h030, 1'b0, 1'b0, 32'h400, 32'h00A00113, 5'd2, 32'h0000000A, 32'h0, 4'h0, 4'h0);
    tick();
    idle();
    check("post_w0", trace_data_o, 32'hA0400030);
    tick();
    check("post_w1", trace_data_o, 32'h00000400);
    tick();
    check("post_w2", trace_data_o, 32'h00A00113);
    tick();
    check("post_w3", trace_data_o, 32'h0000000A);
    check("post_w3_last", 32'(trace_last_o), 32'd1);
    tick();
    check("post_done_valid", 32'(trace_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
